mem_stage_ctrl: RTL

- MEM-stage data-memory access unit of the 5-stage pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB register. Consumes the MemRead/MemWrite controls, the ALU address and the store data from EX/MEM.
- Performs a multi-cycle access to a local word RAM and drives the 32-bit read data that MEM/WB latches.
- Asserts a stall back to the hazard unit while an access is in flight, so the upstream registers hold.

---
 rtl/mem_stage_pkg.sv | 13 +
 rtl/dmem_sp_ram.sv | 46 ++++
 rtl/mem_stage_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_sp_ram.sv
// Single-port synchronous data RAM with a read-enabled, resettable output register.
// The output register only updates on a read, so it holds the last load result.
module dmem_sp_ram
    import mem_stage_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int IDX_W       = 7
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[idx_i];
        end
    end

    // NOTE: the array has no reset so it maps onto RAM macros; only the output register is reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage access controller: IDLE/WAIT/RESP FSM with LAT wait cycles and a pipeline stall.
// Optional misaligned-request rejection is enabled by defining MEM_MISALIGN_CHK_EN.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int LAT         = 2
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              misalign_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               store_q, store_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               misalign_q, misalign_d;
    logic               req;
    logic               misaligned;
    logic               ram_we, ram_re;
    logic               unused_bits;

    assign req = MemRead_i | MemWrite_i;

`ifdef MEM_MISALIGN_CHK_EN
    assign misaligned = (addr_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Upper address bits wrap the index modulo the RAM size.
    assign unused_bits = ^{addr_i[31:IDX_W+2], addr_i[1:0], misalign_q};

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        store_d    = store_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        misalign_d = misalign_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    store_d    = MemWrite_i;
                    idx_d      = addr_i[IDX_W+1:2];
                    wdata_d    = wdata_i;
                    cnt_d      = CNT_W'(LAT);
                    misalign_d = misaligned;
                    state_d    = misaligned ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    ram_we  = store_q;
                    ram_re  = ~store_q;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A store pending when reset hits is dropped rather than written.
        if (!rst_n) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            store_q    <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            store_q    <= store_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            misalign_q <= misalign_d;
        end
    end

    dmem_sp_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .we_i   (ram_we),
        .re_i   (ram_re),
        .idx_i  (idx_q),
        .wdata_i(wdata_q),
        .rdata_o(rdata_o)
    );

    assign stall_o = rst_n & (((state_q == IDLE) & req) | (state_q == WAIT));
    assign done_o  = rst_n & (state_q == RESP);

`ifdef MEM_MISALIGN_CHK_EN
    assign misalign_o = rst_n & (state_q == RESP) & misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

endmodule
